// File: rtl/arm_mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle ARM control sequencer:
// FSM state encoding, condition codes, ALU opcodes, ALU operand-source
// selects and the instruction class field (ir[27:26]).
package arm_defs;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_EOR = 4'h1,
    ALU_SUB = 4'h2,
    ALU_RSB = 4'h3,
    ALU_ADD = 4'h4,
    ALU_ADC = 4'h5,
    ALU_SBC = 4'h6,
    ALU_RSC = 4'h7,
    ALU_TST = 4'h8,
    ALU_TEQ = 4'h9,
    ALU_CMP = 4'hA,
    ALU_CMN = 4'hB,
    ALU_ORR = 4'hC,
    ALU_MOV = 4'hD,
    ALU_BIC = 4'hE,
    ALU_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUSRC_UIMM12 = 2'b00,
    ALUSRC_SHREG  = 2'b01,
    ALUSRC_ROTIMM = 2'b10
  } alusrc_e;

  typedef enum logic [1:0] {
    CLASS_DP  = 2'b00,
    CLASS_MEM = 2'b01,
    CLASS_BR  = 2'b10,
    CLASS_UND = 2'b11
  } iclass_e;

  // TST/TEQ/CMP/CMN only update flags and never write a register.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
  endfunction

endpackage

// File: rtl/arm_mc_sequencer_cond.sv
// Combinational ARM condition evaluator.
// Ports:
//   cond  [3:0]  condition field ir[31:28]
//   flags [3:0]  architectural NZCV (N=3, Z=2, C=1, V=0)
//   pass         1 when the instruction should execute
module arm_cond_check
  import arm_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the shared
// ARM datapath. Owns PC, IR, NZCV and the retired-instruction counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (variable latency)
//   dmem_req/we/ack          data access handshake (we=1 store)
//   alu_result, alu_nzcv     datapath ALU output and flags
//   ir, pc, nzcv             architectural state
//   alu_op, alu_src          ALU opcode and operand-source select
//   rf_we, rf_link           register write / link-register write pulses
//   mem_to_reg               writeback selects load data
//   instret                  retired instruction count (wraps)
//   halted                   sticky undefined-instruction trap
module arm_mc_sequencer
  import arm_defs::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        nzcv,
  output logic [3:0]        alu_op,
  output logic [1:0]        alu_src,
  output logic              rf_we,
  output logic              rf_link,
  output logic              mem_to_reg,
  output logic [CNT_W-1:0]  instret,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  // Holds off the first fetch for one cycle so req is low the cycle after rst.
  logic              boot_q;

  iclass_e           iclass;
  logic              cond_pass;
  logic              is_load;
  logic [3:0]        rd;
  logic [3:0]        dp_op;
  logic [ADDR_W-1:0] pc_seq;
  logic signed [25:0] br_off_s;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;

  logic              retire;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;

  assign iclass    = iclass_e'(ir_q[27:26]);
  assign is_load   = ir_q[20];
  assign rd        = ir_q[15:12];
  assign dp_op     = ir_q[24:21];
  assign pc_seq    = pc_q + ADDR_W'(PC_STEP);
  assign br_off_s  = {ir_q[23:0], 2'b00};
  assign br_off    = ADDR_W'(br_off_s);
  assign br_target = pc_seq + br_off;

  arm_cond_check u_cond (
    .cond  (ir_q[31:28]),
    .flags (nzcv_q),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      nzcv_q    <= '0;
      instret_q <= '0;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      nzcv_q    <= nzcv_d;
      instret_q <= instret_d;
      boot_q    <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    nzcv_d     = nzcv_q;
    instret_d  = instret_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    rf_link    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    pc_load    = 1'b0;
    pc_target  = pc_seq;

    case (state_q)
      ST_FETCH: begin
        if (!boot_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        // A failing condition retires before the class is looked at, so a
        // never-executed undefined encoding does not trap.
        if (!cond_pass) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (iclass == CLASS_UND) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (iclass)
          CLASS_DP: begin
            if (ir_q[20]) nzcv_d = alu_nzcv;
            if (is_test_op(dp_op)) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
          CLASS_BR: begin
            rf_link   = ir_q[24];
            retire    = 1'b1;
            pc_load   = 1'b1;
            pc_target = br_target;
            state_d   = ST_FETCH;
          end
          CLASS_MEM: begin
            state_d = ir_q[25] ? ST_HALT : ST_MEM;
          end
          default: state_d = ST_HALT;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ~is_load;
        if (dmem_ack) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        mem_to_reg = (iclass == CLASS_MEM) && is_load;
        retire     = 1'b1;
        state_d    = ST_FETCH;
        // r15 is not in the register file: the datapath presents the
        // writeback value (ALU or load data) on alu_result for the PC.
        if (rd == 4'hF) begin
          pc_load   = 1'b1;
          pc_target = alu_result;
        end else begin
          rf_we = 1'b1;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: state_d = ST_FETCH;
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      pc_d      = pc_load ? pc_target : pc_seq;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign nzcv      = nzcv_q;
  assign instret   = instret_q;
  assign halted    = (state_q == ST_HALT);
  assign alu_op    = (iclass == CLASS_MEM) ? ALU_ADD : dp_op;

  always_comb begin
    alu_src = ALUSRC_UIMM12;
    if (iclass == CLASS_DP) alu_src = ir_q[25] ? ALUSRC_ROTIMM : ALUSRC_SHREG;
  end

endmodule

// File: tb/tb_arm_mc_sequencer.sv
module tb_arm_mc_sequencer;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic [ADDR_W-1:0] alu_result;
  logic [3:0]        alu_nzcv;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        nzcv;
  logic [3:0]        alu_op;
  logic [1:0]        alu_src;
  logic              rf_we;
  logic              rf_link;
  logic              mem_to_reg;
  logic [CNT_W-1:0]  instret;
  logic              halted;

  arm_mc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0),
    .PC_STEP  (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .alu_result (alu_result),
    .alu_nzcv   (alu_nzcv),
    .ir         (ir),
    .pc         (pc),
    .nzcv       (nzcv),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .rf_we      (rf_we),
    .rf_link    (rf_link),
    .mem_to_reg (mem_to_reg),
    .instret    (instret),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction supplied by the memory model, with its latencies and the
  // ALU values the datapath would present while it executes.
  typedef struct {
    logic [31:0] instr;
    int unsigned iwait;
    int unsigned dwait;
    logic [3:0]  flags;
    logic [31:0] res;
  } fetch_t;

  // Expected state at each retirement.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [3:0]  nzcv;
    int unsigned nwe;
    int unsigned nlink;
    int unsigned nm2r;
    int unsigned cyc;
    int unsigned nd;
    logic        we;
  } ret_t;

  // Expected outputs in one specific cycle.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [3:0]  nzcv;
    logic        halt;
    logic        ireq;
    logic        dreq;
    logic        strb;
  } snap_t;

  fetch_t iq[$];
  ret_t   rq[$];
  snap_t  sq[$];
  int unsigned ip;
  int unsigned rp;
  int unsigned sp;
  logic        noise;
  int unsigned checks;
  int unsigned failures;

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, got, exp);
    end
  endtask

  // Memory model: sole driver of the memory-side inputs.
  initial begin
    int unsigned icnt;
    int unsigned dcnt;
    fetch_t      cur;
    icnt = 0;
    dcnt = 0;
    ip   = 0;
    cur  = '{instr: '0, iwait: 0, dwait: 0, flags: '0, res: '0};
    imem_ack   = 1'b0;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    alu_nzcv   = '0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (noise) begin
        // Spurious acks carrying an undefined opcode: must have no effect.
        imem_ack   = 1'b1;
        dmem_ack   = 1'b1;
        imem_rdata = 32'hEF000000;
        icnt = 0;
        dcnt = 0;
      end else begin
        if (imem_req && ip < iq.size()) begin
          if (icnt == iq[ip].iwait) begin
            imem_ack   = 1'b1;
            imem_rdata = iq[ip].instr;
            alu_nzcv   = iq[ip].flags;
            alu_result = iq[ip].res;
            cur        = iq[ip];
            ip++;
            icnt = 0;
          end else begin
            icnt++;
          end
        end else if (!imem_req) begin
          icnt = 0;
        end
        if (dmem_req) begin
          if (dcnt == cur.dwait) begin
            dmem_ack = 1'b1;
            dcnt = 0;
          end else begin
            dcnt++;
          end
        end else begin
          dcnt = 0;
        end
      end
    end
  end

  // Monitor: compares snapshots and, on every instret change, the next
  // expected retirement record.
  initial begin
    logic [31:0] prev;
    int unsigned cyc, nwe, nlink, nm2r, nd;
    logic        we_seen, active;
    snap_t       s;
    ret_t        r;
    checks = 0;
    failures = 0;
    rp = 0;
    sp = 0;
    prev = '0;
    cyc = 0; nwe = 0; nlink = 0; nm2r = 0; nd = 0;
    we_seen = 1'b0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (sp < sq.size()) begin
        s = sq[sp];
        chk("snap_pc", sp, pc, s.pc);
        chk("snap_instret", sp, instret, s.cnt);
        chk("snap_nzcv", sp, 32'(nzcv), 32'(s.nzcv));
        chk("snap_halted", sp, 32'(halted), 32'(s.halt));
        chk("snap_imem_req", sp, 32'(imem_req), 32'(s.ireq));
        chk("snap_dmem_req", sp, 32'(dmem_req), 32'(s.dreq));
        chk("snap_strobes", sp, 32'(rf_we | rf_link), 32'(s.strb));
        sp++;
      end
      if (rst) begin
        prev = instret;
        cyc = 0; nwe = 0; nlink = 0; nm2r = 0; nd = 0;
        we_seen = 1'b0;
        active = 1'b0;
      end else begin
        if (instret != prev) begin
          if (rp < rq.size()) begin
            r = rq[rp];
            chk("ret_pc", rp, pc, r.pc);
            chk("ret_instret", rp, instret, r.cnt);
            chk("ret_nzcv", rp, 32'(nzcv), 32'(r.nzcv));
            chk("ret_rf_we_pulses", rp, nwe, r.nwe);
            chk("ret_rf_link_pulses", rp, nlink, r.nlink);
            chk("ret_mem_to_reg_pulses", rp, nm2r, r.nm2r);
            chk("ret_cycles", rp, cyc, r.cyc);
            chk("ret_dmem_req_cycles", rp, nd, r.nd);
            chk("ret_dmem_we", rp, 32'(we_seen), 32'(r.we));
            rp++;
          end else begin
            chk("retire_count", rp, rp + 1, rq.size());
          end
          prev = instret;
          cyc = 0; nwe = 0; nlink = 0; nm2r = 0; nd = 0;
          we_seen = 1'b0;
          active = 1'b0;
        end
        if (imem_req) active = 1'b1;
        if (active) cyc++;
        if (rf_we) nwe++;
        if (rf_link) nlink++;
        if (rf_we && mem_to_reg) nm2r++;
        if (dmem_req) begin
          nd++;
          if (dmem_we) we_seen = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ins(input logic [31:0] instr, input int unsigned iw,
                     input int unsigned dw, input logic [3:0] fl, input logic [31:0] res);
    iq.push_back('{instr: instr, iwait: iw, dwait: dw, flags: fl, res: res});
  endtask

  task automatic exp_ret(input logic [31:0] epc, input logic [31:0] ecnt, input logic [3:0] enz,
                         input int unsigned ewe, input int unsigned elink, input int unsigned em2r,
                         input int unsigned ecyc, input int unsigned end_, input logic ewe_mem);
    rq.push_back('{pc: epc, cnt: ecnt, nzcv: enz, nwe: ewe, nlink: elink, nm2r: em2r,
                   cyc: ecyc, nd: end_, we: ewe_mem});
  endtask

  task automatic exp_snap(input logic [31:0] epc, input logic [31:0] ecnt, input logic [3:0] enz,
                          input logic eh, input logic eir, input logic edr);
    sq.push_back('{pc: epc, cnt: ecnt, nzcv: enz, halt: eh, ireq: eir, dreq: edr, strb: 1'b0});
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (!(ip == iq.size() && rp == rq.size() && sp == sq.size())) begin
      step();
      n++;
      if (n > 400) begin
        $display("FAIL drain_timeout ip=%0d/%0d rp=%0d/%0d", ip, iq.size(), rp, rq.size());
        $fatal(1);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    noise = 1'b0;
    step();
    step();
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

    //   instr         iw dw flags  alu_result
    ins(32'hE2811001, 0, 0, 4'hF, 32'h0);   // ADD r1,r1,#1 (no S: flags ignored)
    ins(32'hE3500000, 0, 0, 4'h6, 32'h0);   // CMP r0,#0
    ins(32'h0A000002, 0, 0, 4'h0, 32'h0);   // BEQ +2 (taken)
    ins(32'h1A000005, 0, 0, 4'h0, 32'h0);   // BNE (fails, Z=1)
    ins(32'hEB000001, 2, 0, 4'h0, 32'h0);   // BL +1, two fetch waits
    ins(32'hE5912004, 0, 3, 4'h0, 32'h0);   // LDR r2,[r1,#4], three data waits
    ins(32'hE5812008, 0, 1, 4'h0, 32'h0);   // STR r2,[r1,#8], one data wait
    ins(32'hE0B12003, 1, 0, 4'h9, 32'h0);   // ADCS r2,r1,r3
    ins(32'hE281F010, 0, 0, 4'h0, 32'h100); // ADD pc,r1,#16 -> pc=0x100
    ins(32'hF2811001, 0, 0, 4'h0, 32'h0);   // NV: never executes

    //      pc         cnt nzcv we lk m2r cyc dmem we
    exp_ret(32'h4,     1,  4'h0, 1, 0, 0, 4, 0, 1'b0);
    exp_ret(32'h8,     2,  4'h6, 0, 0, 0, 3, 0, 1'b0);
    exp_ret(32'h14,    3,  4'h6, 0, 0, 0, 3, 0, 1'b0);
    exp_ret(32'h18,    4,  4'h6, 0, 0, 0, 2, 0, 1'b0);
    exp_ret(32'h20,    5,  4'h6, 0, 1, 0, 5, 0, 1'b0);
    exp_ret(32'h24,    6,  4'h6, 1, 0, 1, 8, 4, 1'b0);
    exp_ret(32'h28,    7,  4'h6, 0, 0, 0, 5, 2, 1'b1);
    exp_ret(32'h2C,    8,  4'h9, 1, 0, 0, 5, 0, 1'b0);
    exp_ret(32'h100,   9,  4'h9, 0, 0, 0, 4, 0, 1'b0);
    exp_ret(32'h104,   10, 4'h9, 0, 0, 0, 2, 0, 1'b0);
    drain();

    // Undefined class traps; spurious acks while halted change nothing.
    ins(32'hEF000000, 0, 0, 4'h0, 32'h0);
    drain();
    step();
    noise = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_snap(32'h104, 10, 4'h9, 1'b1, 1'b0, 1'b0);
      step();
    end

    // Reset out of halt; acks during reset and the boot cycle are ignored.
    rst = 1'b1;
    step();
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    ins(32'hE2811001, 5, 0, 4'h0, 32'h0);
    exp_ret(32'h4, 1, 4'h0, 1, 0, 0, 9, 0, 1'b0);
    step();
    noise = 1'b0;
    step();
    step();
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Abort the pending fetch with reset; it restarts from the reset PC.
    rst   = 1'b1;
    noise = 1'b1;
    step();
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    exp_snap(32'h0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    noise = 1'b0;
    drain();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
